// File: rtl/adaptive_input_port.sv
// Router input port: a small flit FIFO plus X-then-Y hop-count route computation
// for the head flit, with optional timeout re-steering from the X output to Y.
module adaptive_input_port #(
  parameter int          DATA_WIDTH    = 64,
  parameter int          BUFFER_DEPTH  = 4,
  parameter logic [4:0]  DIRECTION     = 5'b00001,
  parameter int          ADAPTIVE      = 1,
  parameter int          ADAPT_TIMEOUT = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  si,
  input  logic [DATA_WIDTH-1:0]                 datai,
  output logic                                  ri,
  input  logic [4:0]                            gnt,
  output logic [4:0]                            reqo,
  output logic [DATA_WIDTH-1:0]                 datao,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     occ,
  output logic                                  adapted
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int OW = $clog2(BUFFER_DEPTH + 1);
  localparam int XD = DATA_WIDTH - 3;
  localparam int YD = DATA_WIDTH - 4;
  localparam int XH = DATA_WIDTH - 9;
  localparam int YH = DATA_WIDTH - 17;

  localparam logic [4:0] L_OUT  = 5'b10000;
  localparam logic [4:0] R_OUT  = 5'b01000;
  localparam logic [4:0] U_OUT  = 5'b00100;
  localparam logic [4:0] D_OUT  = 5'b00010;
  localparam logic [4:0] PE_OUT = 5'b00001;

  typedef enum logic [1:0] {S_EMPTY, S_PRI, S_ALT} state_t;

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [OW-1:0]         r_occ;
  state_t                r_state;
  logic [7:0]            r_blk_cnt;

  logic [DATA_WIDTH-1:0] w_head;
  logic [7:0]            w_xhops;
  logic [7:0]            w_yhops;
  logic [4:0]            w_x_out;
  logic [4:0]            w_y_out;
  logic [4:0]            w_pri_out;
  logic [DATA_WIDTH-1:0] w_pri_data;
  logic [DATA_WIDTH-1:0] w_alt_data;
  logic                  w_uturn;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_adapt_go;
  logic [OW-1:0]         w_occ_nxt;
  state_t                w_state_nxt;
  logic [7:0]            w_blk_nxt;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_xhops = w_head[XH -: 8];
  assign w_yhops = w_head[YH -: 8];

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_x_out    = w_head[XD] ? L_OUT : R_OUT;
    w_y_out    = w_head[YD] ? D_OUT : U_OUT;
    w_pri_out  = PE_OUT;
    w_pri_data = w_head;
    w_alt_data = w_head;
    w_alt_data[YH -: 8] = w_yhops - 8'd1;
    if (w_xhops != 8'd0) begin
      w_pri_out = w_x_out;
      w_pri_data[XH -: 8] = w_xhops - 8'd1;
    end else if (w_yhops != 8'd0) begin
      w_pri_out = w_y_out;
      w_pri_data[YH -: 8] = w_yhops - 8'd1;
    end
  end

  // A flit routed back out of the side it arrived on can never be served.
  assign w_uturn = (w_pri_out == DIRECTION) && (DIRECTION != PE_OUT);

  always_comb begin
    reqo    = '0;
    datao   = '0;
    adapted = 1'b0;
    unique case (r_state)
      S_PRI: begin
        reqo  = w_uturn ? 5'b00000 : w_pri_out;
        datao = w_pri_data;
      end
      S_ALT: begin
        reqo    = w_y_out;
        datao   = w_alt_data;
        adapted = 1'b1;
      end
      default: ;
    endcase
  end

  assign occ        = r_occ;
  assign ri         = (r_occ != OW'(BUFFER_DEPTH));
  assign w_push     = si & ri;
  assign w_pop      = |(gnt & reqo);
  assign w_occ_nxt  = r_occ + OW'(w_push) - OW'(w_pop);
  assign w_adapt_go = (ADAPTIVE != 0) && (r_blk_cnt == 8'(ADAPT_TIMEOUT - 1)) &&
                      (w_xhops != 8'd0) && (w_yhops != 8'd0) && (w_y_out != DIRECTION);

  always_comb begin
    w_state_nxt = r_state;
    w_blk_nxt   = r_blk_cnt;
    unique case (r_state)
      S_EMPTY: begin
        w_blk_nxt = 8'd0;
        if (w_push) w_state_nxt = S_PRI;
      end
      default: begin
        if (w_pop) begin
          w_blk_nxt   = 8'd0;
          w_state_nxt = (w_occ_nxt != '0) ? S_PRI : S_EMPTY;
        end else if (r_state == S_PRI) begin
          if (w_adapt_go) begin
            w_state_nxt = S_ALT;
            w_blk_nxt   = 8'd0;
          end else if (r_blk_cnt != 8'hFF) begin
            w_blk_nxt = r_blk_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  // NOTE: flit storage is not reset; pointers and occupancy alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wr_ptr] <= datai;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_state   <= S_EMPTY;
      r_blk_cnt <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_occ     <= w_occ_nxt;
      r_state   <= w_state_nxt;
      r_blk_cnt <= w_blk_nxt;
    end
  end

  a_no_uturn: assert property (@(posedge clk) disable iff (!rst) !((r_state == S_PRI) && w_uturn));

endmodule

// File: tb/tb_adaptive_input_port.sv
// Bench for adaptive_input_port: an adaptive and a non-adaptive instance share one
// stimulus stream and are each checked every cycle against a flit-queue model.
module tb_adaptive_input_port;

  localparam int         DEPTH = 4;
  localparam int         TMO   = 4;
  localparam logic [4:0] DIR   = 5'b00001;
  localparam logic [4:0] L_OUT = 5'b10000;
  localparam logic [4:0] R_OUT = 5'b01000;
  localparam logic [4:0] U_OUT = 5'b00100;
  localparam logic [4:0] D_OUT = 5'b00010;
  localparam logic [4:0] PE_OUT = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        si;
  logic [63:0] datai;
  logic [4:0]  gnt;

  logic        ri_o      [2];
  logic [2:0]  occ_o     [2];
  logic [4:0]  reqo_o    [2];
  logic [63:0] datao_o   [2];
  logic        adapted_o [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adaptive_input_port #(.DATA_WIDTH(64), .BUFFER_DEPTH(DEPTH), .DIRECTION(DIR),
                        .ADAPTIVE(1), .ADAPT_TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .si(si), .datai(datai), .ri(ri_o[0]), .gnt(gnt),
    .reqo(reqo_o[0]), .datao(datao_o[0]), .occ(occ_o[0]), .adapted(adapted_o[0]));

  adaptive_input_port #(.DATA_WIDTH(64), .BUFFER_DEPTH(DEPTH), .DIRECTION(DIR),
                        .ADAPTIVE(0), .ADAPT_TIMEOUT(TMO)) dut_n (
    .clk(clk), .rst(rst), .si(si), .datai(datai), .ri(ri_o[1]), .gnt(gnt),
    .reqo(reqo_o[1]), .datao(datao_o[1]), .occ(occ_o[1]), .adapted(adapted_o[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input bit xd, input bit yd, input logic [7:0] xh,
                                     input logic [7:0] yh, input logic [39:0] pl);
    return {2'b00, xd, yd, 4'h0, xh, yh, pl};
  endfunction

  // Model: instance 0 adaptive, instance 1 pure X-then-Y. Queue kept as a shifting array.
  logic [63:0] m_fl   [2][DEPTH];
  int          m_n    [2];
  int          m_wait [2];
  bit          m_alt  [2];
  bit          m_live = 1'b0;

  function automatic void expect_out(input int k, output logic [4:0] req,
                                     output logic [63:0] dat, output logic ad);
    logic [63:0] h;
    logic [7:0]  x;
    logic [7:0]  y;
    h = m_fl[k][0];
    x = h[55:48];
    y = h[47:40];
    req = 5'b0; dat = 64'b0; ad = 1'b0;
    if (m_n[k] == 0) return;
    dat = h;
    if (m_alt[k]) begin
      req = h[60] ? D_OUT : U_OUT;
      dat[47:40] = y - 8'd1;
      ad = 1'b1;
    end else if (x != 8'd0) begin
      req = h[61] ? L_OUT : R_OUT;
      dat[55:48] = x - 8'd1;
    end else if (y != 8'd0) begin
      req = h[60] ? D_OUT : U_OUT;
      dat[47:40] = y - 8'd1;
    end else begin
      req = PE_OUT;
    end
  endfunction

  always @(posedge clk) begin
    logic [4:0]  req;
    logic [63:0] dat;
    logic        ad;
    logic [63:0] h;
    bit          pop;
    bit          push;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_n[k] = 0; m_wait[k] = 0; m_alt[k] = 1'b0;
      end else begin
        expect_out(k, req, dat, ad);
        h    = m_fl[k][0];
        pop  = (m_n[k] > 0) && ((gnt & req) != 5'b0);
        push = si && (m_n[k] < DEPTH);
        if (pop) begin
          for (int j = 0; j < DEPTH - 1; j++) m_fl[k][j] = m_fl[k][j+1];
          m_n[k]--; m_wait[k] = 0; m_alt[k] = 1'b0;
        end else if (m_n[k] > 0 && !m_alt[k]) begin
          m_wait[k]++;
          if (k == 0 && m_wait[k] == TMO && h[55:48] != 8'd0 && h[47:40] != 8'd0 &&
              (h[60] ? D_OUT : U_OUT) != DIR)
            m_alt[k] = 1'b1;
        end
        if (push) begin
          m_fl[k][m_n[k]] = datai;
          m_n[k]++;
        end
      end
    end
    if (!rst) m_live = 1'b1;
  end

  always @(negedge clk) begin
    logic [4:0]  req;
    logic [63:0] dat;
    logic        ad;
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        expect_out(k, req, dat, ad);
        check($sformatf("ri[%0d]", k),      ri_o[k],      (m_n[k] < DEPTH));
        check($sformatf("occ[%0d]", k),     occ_o[k],     m_n[k]);
        check($sformatf("reqo[%0d]", k),    reqo_o[k],    req);
        check($sformatf("datao[%0d]", k),   datao_o[k],   dat);
        check($sformatf("adapted[%0d]", k), adapted_o[k], ad);
      end
    end
  end

  task automatic step(input logic s, input logic [63:0] d, input logic [4:0] g);
    si = s; datai = d; gnt = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] f;
    rst = 1'b0; si = 1'b1; datai = mk(0, 0, 0, 0, 40'hDEAD); gnt = 5'b0;

    // Reset held with si=1: nothing captured.
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_occ", occ_o[0], 0);
      check("rst_ri", ri_o[0], 1);
    end
    rst = 1'b1;
    step(0, 64'b0, 5'b0);
    check("post_rst_occ", occ_o[0], 0);
    check("post_rst_reqo", reqo_o[0], 5'b0);
    check("post_rst_ri", ri_o[0], 1);
    check("post_rst_datao", datao_o[0], 64'b0);
    check("post_rst_adapted", adapted_o[0], 0);

    // X route R with hop decrement, popped by matching grant.
    f = mk(0, 0, 8'd3, 8'd2, 40'hA1);
    step(1, f, 5'b0);
    check("xr_reqo", reqo_o[0], 5'b01000);
    check("xr_xhops", datao_o[0][55:48], 8'd2);
    check("xr_yhops", datao_o[0][47:40], 8'd2);
    check("xr_occ", occ_o[1], 1);
    step(0, 64'b0, 5'b01000);
    check("xr_pop_occ", occ_o[0], 0);
    check("xr_pop_reqo", reqo_o[1], 5'b0);

    // Fill to full, reject a fifth, then one grant.
    for (int i = 0; i < 4; i++) step(1, mk(0, 0, 0, 0, 40'(i + 16)), 5'b0);
    check("full_occ", occ_o[0], 4);
    check("full_ri", ri_o[0], 0);
    step(1, mk(0, 0, 0, 0, 40'd99), 5'b0);
    check("reject_occ", occ_o[0], 4);
    si = 1'b1; datai = mk(0, 0, 0, 0, 40'd77); gnt = PE_OUT;
    #1;
    check("pop_cycle_ri", ri_o[0], 0);
    @(posedge clk); #1;
    check("after_pop_occ", occ_o[0], 3);
    check("after_pop_ri", ri_o[0], 1);
    check("after_pop_head", datao_o[0], mk(0, 0, 0, 0, 40'd17));
    repeat (3) step(0, 64'b0, PE_OUT);
    check("drain_occ", occ_o[0], 0);

    // Blocked head: adaptive instance re-steers to U after TMO cycles.
    f = mk(0, 0, 8'd1, 8'd1, 40'hBEEF);
    step(1, f, 5'b0);
    check("blk_reqo_0", reqo_o[0], R_OUT);
    for (int i = 1; i < TMO; i++) begin
      step(0, 64'b0, 5'b0);
      check("blk_reqo", reqo_o[0], R_OUT);
    end
    step(0, 64'b0, 5'b0);
    check("alt_reqo", reqo_o[0], U_OUT);
    check("alt_adapted", adapted_o[0], 1);
    check("alt_yhops", datao_o[0][47:40], 8'd0);
    check("alt_xhops", datao_o[0][55:48], 8'd1);
    check("nonadapt_reqo", reqo_o[1], R_OUT);
    check("nonadapt_adapted", adapted_o[1], 0);
    repeat (8) step(0, 64'b0, 5'b0);
    check("nonadapt_still_r", reqo_o[1], R_OUT);
    step(0, 64'b0, R_OUT);
    check("late_r_ignored_occ", occ_o[0], 1);
    check("late_r_ignored_reqo", reqo_o[0], U_OUT);
    check("nonadapt_popped", occ_o[1], 0);
    step(0, 64'b0, U_OUT);
    check("alt_popped", occ_o[0], 0);

    // yhops=0: no re-steer even when adaptive.
    step(1, mk(0, 0, 8'd1, 8'd0, 40'h55), 5'b0);
    repeat (10) step(0, 64'b0, 5'b0);
    check("noy_reqo", reqo_o[0], R_OUT);
    check("noy_adapted", adapted_o[0], 0);
    step(0, 64'b0, R_OUT);
    check("noy_pop", occ_o[0], 0);

    // Streaming across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      f = mk(i[0], i[1], 0, 0, 40'(i * 40'h1357 + 40'h3));
      step(1, f, PE_OUT);
      check("stream_occ", occ_o[0], 1);
      check("stream_head", datao_o[0], f);
    end
    step(0, 64'b0, PE_OUT);
    check("stream_end_occ", occ_o[0], 0);

    repeat (2) step(0, 64'b0, 5'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
